// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage RV32I hazard controller.
// Detects RAW hazards, steers EX-operand and store-data forwarding, flushes
// on taken branches/jumps (optionally over several cycles), freezes the
// pipeline on a slow data memory, and keeps saturating stall/flush counters.
module hazard_ctrl #(
    parameter int FWD_EN       = 1,
    parameter int RF_BYPASS    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    // ID stage
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_rs1_used,
    input  logic             d_rs2_used,
    // EX stage
    input  logic [4:0]       e_rs1,
    input  logic [4:0]       e_rs2,
    input  logic [4:0]       e_rd,
    input  logic             e_regwren,
    input  logic             e_memren,
    input  logic             e_br_taken,
    input  logic             e_is_jump,
    // MEM stage
    input  logic [4:0]       m_rd,
    input  logic [4:0]       m_rs2,
    input  logic             m_regwren,
    input  logic             m_memren,
    input  logic             m_memwren,
    input  logic             m_mem_ready,
    // WB stage
    input  logic [4:0]       w_rd,
    input  logic             w_regwren,
    // pipeline control
    output logic             stall_if,
    output logic             ifid_wren,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_wren,
    output logic             exmem_wren,
    output logic             memwb_bubble,
    output logic [1:0]       rs1_sel,
    output logic [1:0]       rs2_sel,
    output logic             wm_fwd_sel,
    // status
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam bit FWD = (FWD_EN != 0);
    localparam bit RFB = (RF_BYPASS != 0);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0]       FCNT_LOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0]  WC_MAX    = WC_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze, redirect, in_redir, hazard;
    logic ex_prod, mem_prod, wb_prod;
    logic [1:0] rs1_fwd, rs2_fwd;
    logic wm_fwd;

    // An ID source register is in flight if any enabled producer targets it.
    function automatic logic raw_on(
        input logic [4:0] r,   input logic used,
        input logic [4:0] erd, input logic ep,
        input logic [4:0] mrd, input logic mp,
        input logic [4:0] wrd, input logic wp
    );
        return used && (r != 5'd0) &&
               ((ep && (erd == r)) || (mp && (mrd == r)) || (wp && (wrd == r)));
    endfunction

    // MEM result is younger than WB, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic mw, input logic [4:0] mrd,
        input logic ww, input logic [4:0] wrd
    );
        if (mw && (mrd != 5'd0) && (mrd == r))
            return 2'b01;
        else if (ww && (wrd != 5'd0) && (wrd == r))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Hazard terms: with forwarding only a load in EX must stall the consumer.
    always_comb begin
        freeze   = (m_memren | m_memwren) & ~m_mem_ready;
        in_redir = (state_q == REDIRECT);
        redirect = (e_br_taken | e_is_jump) & ~freeze & ~in_redir;
        ex_prod  = FWD ? e_memren : e_regwren;
        mem_prod = ~FWD & m_regwren;
        wb_prod  = ~RFB & w_regwren;
        hazard   = raw_on(d_rs1, d_rs1_used, e_rd, ex_prod, m_rd, mem_prod, w_rd, wb_prod) |
                   raw_on(d_rs2, d_rs2_used, e_rd, ex_prod, m_rd, mem_prod, w_rd, wb_prod);
    end

    // Forwarding selects; all zero when forwarding is built out or in reset.
    always_comb begin
        rs1_fwd = 2'b00;
        rs2_fwd = 2'b00;
        wm_fwd  = 1'b0;
        if (FWD && !reset) begin
            rs1_fwd = fwd_sel(e_rs1, m_regwren, m_rd, w_regwren, w_rd);
            rs2_fwd = fwd_sel(e_rs2, m_regwren, m_rd, w_regwren, w_rd);
            wm_fwd  = m_memwren & w_regwren & (w_rd != 5'd0) & (w_rd == m_rs2);
        end
    end

    // Pipeline control outputs in priority order: reset, freeze, redirect, hazard.
    always_comb begin
        stall_if     = 1'b0;
        ifid_wren    = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        idex_wren    = 1'b1;
        exmem_wren   = 1'b1;
        memwb_bubble = 1'b0;
        if (reset) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            stall_if     = 1'b1;
            ifid_wren    = 1'b0;
            idex_wren    = 1'b0;
            exmem_wren   = 1'b0;
            memwb_bubble = 1'b1;
        end else if (redirect) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (in_redir) begin
            // Extra fetch-side flush cycles; EX only carries bubbles now.
            ifid_flush   = 1'b1;
        end else if (hazard) begin
            stall_if     = 1'b1;
            ifid_wren    = 1'b0;
            idex_flush   = 1'b1;
        end
    end

    assign rs1_sel    = rs1_fwd;
    assign rs2_sel    = rs2_fwd;
    assign wm_fwd_sel = wm_fwd;

    // Redirect FSM: counts the remaining IF/ID flush cycles, paused by freeze.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (redirect && (FLUSH_CYCLES > 1)) begin
                    state_d = REDIRECT;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            REDIRECT: begin
                if (!freeze) begin
                    if (fcnt_q <= 2'd1) begin
                        state_d = RUN;
                        fcnt_d  = 2'd0;
                    end else begin
                        fcnt_d  = fcnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 2'd0;
            end
        endcase
    end

    // Memory-wait watchdog and saturating performance counters.
    always_comb begin
        wcnt_d      = '0;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze)
            wcnt_d = (wcnt_q == WC_MAX) ? wcnt_q : wcnt_q + 1'b1;
        if (wcnt_d == WC_MAX)
            mem_err_d = 1'b1;
        if (stall_if && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (redirect && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            fcnt_q      <= 2'd0;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mem_err   = mem_err_q;

endmodule
